// File: rtl/interrupt_controller_pkg.sv
// Encodings shared by the interrupt-entry sequencer, the memory-stage push mux
// and the fetch PC mux.
package interrupt_controller_pkg;

    localparam logic [31:0] DEFAULT_VECTOR_PC = 32'h0000_0000;
    localparam int unsigned DRAIN_CNT_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FREEZE,
        ST_DRAIN,
        ST_PUSH_HI,
        ST_PUSH_LO,
        ST_PUSH_FL,
        ST_VECTOR
    } int_state_t;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'b00,
        SEL_PCLO  = 2'b01,
        SEL_PCHI  = 2'b10,
        SEL_FLAGS = 2'b11
    } push_sel_t;

endpackage

// File: rtl/interrupt_controller_if.sv
// Interrupt-save interface between the entry sequencer (master) and the
// pipeline / memory stage (slave).
interface interrupt_controller_if #(
    parameter int unsigned PC_W = 32
);
    logic              int_in;
    logic [PC_W-1:0]   pc_in;
    logic [3:0]        flags_in;
    logic              branch_in_flight;
    logic              rti_done;

    logic              pc_stall;
    logic              if_flush;
    logic              id_flush;
    logic              mem_write;
    logic              dec_sp;
    logic              int_mem_selector1;
    logic              int_mem_selector2;
    logic [15:0]       push_data;
    logic              vector_load;
    logic [PC_W-1:0]   vector_pc;
    logic              int_active;
    logic              busy;

    modport master (
        input  int_in, pc_in, flags_in, branch_in_flight, rti_done,
        output pc_stall, if_flush, id_flush, mem_write, dec_sp,
               int_mem_selector1, int_mem_selector2, push_data,
               vector_load, vector_pc, int_active, busy
    );

    modport slave (
        output int_in, pc_in, flags_in, branch_in_flight, rti_done,
        input  pc_stall, if_flush, id_flush, mem_write, dec_sp,
               int_mem_selector1, int_mem_selector2, push_data,
               vector_load, vector_pc, int_active, busy
    );
endinterface

// File: rtl/interrupt_controller_edge_detect.sv
// Registers the external interrupt line and produces a one-cycle rising-edge
// pulse.
module int_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic int_in,
    output logic rise
);
    logic r_int_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_int_q <= 1'b0;
        else       r_int_q <= int_in;
    end

    assign rise = int_in & ~r_int_q;
endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer: latches a request and walks the pipeline through
// freeze, flush, drain, a three-word context push and the fetch redirect.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned     DRAIN_CYCLES = 3,
    parameter int unsigned     PC_W         = 32,
    parameter logic [PC_W-1:0] VECTOR_PC    = PC_W'(DEFAULT_VECTOR_PC)
) (
    input  logic                   clk,
    input  logic                   reset,
    interrupt_controller_if.master bus
);
    int_state_t             r_state, w_state_nxt;
    logic                   r_pending;
    logic                   r_int_active;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt;
    logic [PC_W-1:0]        r_saved_pc;
    logic [3:0]             r_saved_flags;

    logic                   w_rise;
    logic                   w_drain_last;
    logic [31:0]            w_pc32;
    push_sel_t              w_sel;
    logic                   w_pc_stall;
    logic                   w_if_flush;
    logic                   w_id_flush;
    logic                   w_push;
    logic                   w_vector_load;
    logic [15:0]            w_push_data;

    int_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .int_in (bus.int_in),
        .rise   (w_rise)
    );

    assign w_drain_last = (r_drain_cnt == DRAIN_CNT_W'(1));
    assign w_pc32       = 32'(r_saved_pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_stall    = 1'b0;
        w_if_flush    = 1'b0;
        w_id_flush    = 1'b0;
        w_push        = 1'b0;
        w_vector_load = 1'b0;
        w_sel         = SEL_NONE;
        w_push_data   = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending && !r_int_active && !bus.branch_in_flight)
                    w_state_nxt = ST_FREEZE;
            end
            ST_FREEZE: begin
                w_pc_stall  = 1'b1;
                w_if_flush  = 1'b1;
                w_id_flush  = 1'b1;
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_pc_stall = 1'b1;
                w_if_flush = 1'b1;
                if (w_drain_last) w_state_nxt = ST_PUSH_HI;
            end
            ST_PUSH_HI: begin
                w_pc_stall  = 1'b1;
                w_push      = 1'b1;
                w_sel       = SEL_PCHI;
                w_push_data = w_pc32[31:16];
                w_state_nxt = ST_PUSH_LO;
            end
            ST_PUSH_LO: begin
                w_pc_stall  = 1'b1;
                w_push      = 1'b1;
                w_sel       = SEL_PCLO;
                w_push_data = w_pc32[15:0];
                w_state_nxt = ST_PUSH_FL;
            end
            ST_PUSH_FL: begin
                w_pc_stall  = 1'b1;
                w_push      = 1'b1;
                w_sel       = SEL_FLAGS;
                w_push_data = {12'b0, r_saved_flags};
                w_state_nxt = ST_VECTOR;
            end
            ST_VECTOR: begin
                w_vector_load = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending     <= 1'b0;
            r_int_active  <= 1'b0;
            r_drain_cnt   <= '0;
            r_saved_pc    <= '0;
            r_saved_flags <= '0;
        end else begin
            // An edge arriving during FREEZE re-arms pending, queueing one request.
            if (w_rise)                    r_pending <= 1'b1;
            else if (r_state == ST_FREEZE) r_pending <= 1'b0;

            if (r_state == ST_VECTOR) r_int_active <= 1'b1;
            else if (bus.rti_done)    r_int_active <= 1'b0;

            if (r_state == ST_FREEZE) begin
                r_saved_pc  <= bus.pc_in;
                r_drain_cnt <= DRAIN_CNT_W'(DRAIN_CYCLES);
            end

            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt - DRAIN_CNT_W'(1);
                if (w_drain_last) r_saved_flags <= bus.flags_in;
            end
        end
    end

    assign bus.pc_stall          = w_pc_stall;
    assign bus.if_flush          = w_if_flush;
    assign bus.id_flush          = w_id_flush;
    assign bus.mem_write         = w_push;
    assign bus.dec_sp            = w_push;
    assign bus.int_mem_selector1 = w_sel[0];
    assign bus.int_mem_selector2 = w_sel[1];
    assign bus.push_data         = w_push_data;
    assign bus.vector_load       = w_vector_load;
    assign bus.vector_pc         = VECTOR_PC;
    assign bus.int_active        = r_int_active;
    assign bus.busy              = (r_state != ST_IDLE);
endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: pushes are scoreboarded,
// sequencing and timing checked from the stimulus side.
module tb_interrupt_controller;
    localparam int unsigned DRAIN = 3;
    localparam logic [31:0] VEC   = 32'h0000_0200;
    localparam int          LAT0  = 5 + DRAIN + 1;
    localparam int          LATF  = 4 + DRAIN;

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] data;
    } push_exp_t;

    logic      clk;
    logic      reset;
    int        n_checks;
    int        n_fail;
    bit        mon_en;
    push_exp_t push_q[$];
    push_exp_t exp_e;

    interrupt_controller_if #(.PC_W(32)) bus ();

    interrupt_controller #(
        .DRAIN_CYCLES (DRAIN),
        .PC_W         (32),
        .VECTOR_PC    (VEC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [1:0] sel, input logic [15:0] data);
        push_q.push_back({sel, data});
    endtask

    task automatic pulse_rti(input string tag);
        bus.rti_done = 1'b1;
        @(negedge clk);
        bus.rti_done = 1'b0;
        check_eq(tag, 32'(bus.int_active), 32'd0);
    endtask

    // Waits for vector_load; n counts negedges from the call. Optionally scrambles
    // pc_in/flags_in after their sample points and adds extra int_in edges.
    task automatic run_to_vector(input string tag, input int exp_n, input int pc_scr_at,
                                 input int fl_scr_at, input int extra_edges);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n >= 2 && n <= 6)
                bus.int_in = (n == 3 && extra_edges >= 1) || (n == 5 && extra_edges >= 2);
            if (n == pc_scr_at) bus.pc_in    = ~bus.pc_in;
            if (n == fl_scr_at) bus.flags_in = ~bus.flags_in;
            check_eq({tag, "_stall"}, 32'(bus.pc_stall), 32'(bus.busy && !bus.vector_load));
        end while (!bus.vector_load && n < 40);
        check_eq({tag, "_vec_lat"}, n, exp_n);
        check_eq({tag, "_vec_pc"}, bus.vector_pc, VEC);
        @(negedge clk);
        check_eq({tag, "_active"}, 32'(bus.int_active), 32'd1);
        check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_write) begin
                if (push_q.size() == 0) begin
                    check_eq("push_unexpected", {14'd0, bus.int_mem_selector2, bus.int_mem_selector1, bus.push_data}, 32'd0);
                end else begin
                    exp_e = push_q.pop_front();
                    check_eq("push_sel", 32'({bus.int_mem_selector2, bus.int_mem_selector1}), 32'(exp_e.sel));
                    check_eq("push_data", 32'(bus.push_data), 32'(exp_e.data));
                    check_eq("push_dec_sp", 32'(bus.dec_sp), 32'd1);
                end
            end else begin
                check_eq("idle_push_outs",
                         32'({bus.dec_sp, bus.int_mem_selector2, bus.int_mem_selector1, bus.push_data}), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  hit;
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        bus.int_in           = 1'b0;
        bus.pc_in            = '0;
        bus.flags_in         = '0;
        bus.branch_in_flight = 1'b0;
        bus.rti_done         = 1'b0;

        // 1: reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl_outs", 32'({bus.pc_stall, bus.if_flush, bus.id_flush, bus.mem_write, bus.dec_sp,
                                       bus.int_mem_selector2, bus.int_mem_selector1, bus.vector_load,
                                       bus.int_active, bus.busy}), 32'd0);
        check_eq("rst_push_data", 32'(bus.push_data), 32'd0);
        check_eq("rst_vector_pc", bus.vector_pc, VEC);
        mon_en = 1'b1;
        reset  = 1'b0;
        repeat (2) @(negedge clk);

        // 2: basic entry
        bus.pc_in    = 32'h0001_0040;
        bus.flags_in = 4'b1010;
        sb_push(2'b10, 16'h0001);
        sb_push(2'b01, 16'h0040);
        sb_push(2'b11, 16'h000A);
        bus.int_in = 1'b1;
        run_to_vector("t2", LAT0, 3, 6, 0);
        check_eq("t2_sb_empty", push_q.size(), 0);
        pulse_rti("t2_rti_clear");

        // 3: entry deferred while a branch is in flight; late branch ignored
        bus.pc_in    = 32'h0002_1234;
        bus.flags_in = 4'b0011;
        sb_push(2'b10, 16'h0002);
        sb_push(2'b01, 16'h1234);
        sb_push(2'b11, 16'h0003);
        bus.branch_in_flight = 1'b1;
        bus.int_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) bus.int_in = 1'b0;
            check_eq("t3_deferred", 32'(bus.busy), 32'd0);
        end
        bus.branch_in_flight = 1'b0;
        @(negedge clk);
        check_eq("t3_freeze_busy", 32'(bus.busy), 32'd1);
        check_eq("t3_freeze_flush", 32'({bus.pc_stall, bus.if_flush, bus.id_flush}), 32'h7);
        bus.branch_in_flight = 1'b1;
        @(negedge clk);
        check_eq("t3_drain_flush", 32'({bus.pc_stall, bus.if_flush, bus.id_flush}), 32'h6);
        run_to_vector("t3", LATF - 1, 0, 3, 0);
        bus.branch_in_flight = 1'b0;

        // 4: edge while int_active is held pending until rti_done
        bus.pc_in    = 32'h00AB_CDEF;
        bus.flags_in = 4'b0110;
        sb_push(2'b10, 16'h00AB);
        sb_push(2'b01, 16'hCDEF);
        sb_push(2'b11, 16'h0006);
        bus.int_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.int_in = 1'b0;
            check_eq("t4_held", 32'(bus.busy), 32'd0);
        end
        pulse_rti("t4_rti_clear");
        check_eq("t4_rti_cycle_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_eq("t4_freeze", 32'(bus.busy), 32'd1);
        run_to_vector("t4", LATF, 1, 4, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("t4_once", 32'(bus.busy), 32'd0);
        end
        pulse_rti("t4_rti2");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("t4_no_repeat", 32'(bus.busy), 32'd0);
        end

        // 5: two extra edges during a sequence queue exactly one more
        bus.pc_in    = 32'h1357_2468;
        bus.flags_in = 4'b1100;
        sb_push(2'b10, 16'h1357);
        sb_push(2'b01, 16'h2468);
        sb_push(2'b11, 16'h000C);
        bus.int_in = 1'b1;
        run_to_vector("t5a", LAT0, 3, 6, 2);
        bus.pc_in    = 32'h1357_2468;
        bus.flags_in = 4'b1100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t5_wait_rti", 32'(bus.busy), 32'd0);
        end
        sb_push(2'b10, 16'h1357);
        sb_push(2'b01, 16'h2468);
        sb_push(2'b11, 16'h000C);
        pulse_rti("t5_rti1");
        @(negedge clk);
        check_eq("t5_freeze", 32'(bus.busy), 32'd1);
        run_to_vector("t5b", LATF, 1, 4, 0);
        pulse_rti("t5_rti2");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("t5_single", 32'(bus.busy), 32'd0);
        end

        // 6: async reset during PUSH_LO with a request still pending
        bus.pc_in    = 32'h0F0F_1111;
        bus.flags_in = 4'b0001;
        sb_push(2'b10, 16'h0F0F);
        sb_push(2'b01, 16'h1111);
        bus.int_in = 1'b1;
        hit = 1'b0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
            bus.int_in = (n == 3);
            if (bus.mem_write && !bus.int_mem_selector2 && bus.int_mem_selector1) hit = 1'b1;
        end while (!hit && n < 20);
        check_eq("t6_reached_push_lo", 32'(hit), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("t6_async_outs", 32'({bus.pc_stall, bus.if_flush, bus.id_flush, bus.mem_write, bus.dec_sp,
                                       bus.int_mem_selector2, bus.int_mem_selector1, bus.vector_load,
                                       bus.int_active, bus.busy}), 32'd0);
        check_eq("t6_async_data", 32'(bus.push_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("t6_pending_dropped", 32'({bus.busy, bus.int_active}), 32'd0);
        end

        check_eq("sb_empty", push_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
